onchip_memory_arbiter: RTL

ONCHIP_MEMORY_ARBITER -- requirements
Module: onchip_memory_arbiter

---
 rtl/onchip_memory_arbiter_pkg.sv | 13 +
 rtl/onchip_memory_arbiter_rr.sv | 21 ++
 rtl/onchip_memory_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/onchip_memory_arbiter_pkg.sv
// Shared defaults and the master-index type for the two-master on-chip memory arbiter.
package onchip_memory_arbiter_pkg;

    localparam int ADDR_W_DEF    = 17;
    localparam int DATA_W_DEF    = 32;
    localparam int NUM_WORDS_DEF = 128000;

    typedef logic master_idx_t;

    // Master 1 is treated as the previous winner so master 0 wins the first contention.
    localparam master_idx_t LAST_GRANT_RST = 1'b1;

endpackage

// File: rtl/onchip_memory_arbiter_rr.sv
// Two-way round-robin grant: a lone requester always wins, and on contention the
// master that did not win last time wins.
module rr_arbiter2
    import onchip_memory_arbiter_pkg::*;
(
    input  logic [1:0]  req,
    input  master_idx_t last,
    output logic [1:0]  grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last == 1'b1) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/onchip_memory_arbiter.sv
// Arbitrates two Avalon-MM masters onto one single-port on-chip memory with
// one-cycle read latency, out-of-range and read+write error detection.
module onchip_memory_arbiter
    import onchip_memory_arbiter_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int NUM_WORDS = NUM_WORDS_DEF
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,

    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,

    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata,

    output logic [15:0]           err_count
);

    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(NUM_WORDS);

    master_idx_t last_grant;
    logic        rd_pend;
    master_idx_t rd_owner;
    logic        rd_zero;

    logic [1:0]  req;
    logic [1:0]  grant;
    master_idx_t gidx;
    logic        accept;
    logic        g_rd;
    logic        g_wr;
    logic        addr_err;
    logic        rw_err;
    logic        rd_acc;
    logic [DATA_W-1:0] rd_data;

    assign req = {m1_read | m1_write, m0_read | m0_write};

    rr_arbiter2 u_rr (
        .req   (req),
        .last  (last_grant),
        .grant (grant)
    );

    assign gidx   = grant[1];
    assign accept = (|grant) & ~reset;

    assign mem_address    = gidx ? m1_address    : m0_address;
    assign mem_byteenable = gidx ? m1_byteenable : m0_byteenable;
    assign mem_writedata  = gidx ? m1_writedata  : m0_writedata;
    assign g_rd           = gidx ? m1_read       : m0_read;
    assign g_wr           = gidx ? m1_write      : m0_write;

    assign addr_err = ({1'b0, mem_address} >= LIMIT);
    assign rw_err   = g_rd & g_wr;
    // A read+write collision is executed as the write, so only a pure read returns data.
    assign rd_acc   = accept & g_rd & ~g_wr;

    assign mem_chipselect = accept & ~addr_err;
    assign mem_write      = mem_chipselect & g_wr;
    assign mem_clken      = ~reset;

    assign m0_waitrequest = reset | (req[0] & ~grant[0]);
    assign m1_waitrequest = reset | (req[1] & ~grant[1]);

    // Out-of-range reads never reached memory, so they return zero instead of stale data.
    assign rd_data          = rd_zero ? '0 : mem_readdata;
    assign m0_readdatavalid = rd_pend & (rd_owner == 1'b0) & ~reset;
    assign m1_readdatavalid = rd_pend & (rd_owner == 1'b1) & ~reset;
    assign m0_readdata      = m0_readdatavalid ? rd_data : '0;
    assign m1_readdata      = m1_readdatavalid ? rd_data : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= LAST_GRANT_RST;
            rd_pend    <= 1'b0;
            rd_owner   <= 1'b0;
            rd_zero    <= 1'b0;
            err_count  <= 16'h0000;
        end else begin
            rd_pend <= rd_acc;
            rd_zero <= addr_err;
            if (accept) begin
                last_grant <= gidx;
                rd_owner   <= gidx;
                if ((addr_err | rw_err) && (err_count != 16'hFFFF))
                    err_count <= err_count + 16'd1;
            end
        end
    end

endmodule
